// File: rtl/vout_ser_pkg.sv
// Shared definitions for the vout serializer.
//   state_t   : serializer FSM states (IDLE / DATA / PAR)
//   cnt_width : bit-counter width for a given word width, minimum 1
//   CNT_W     : counter width at the default 6-bit word
package vout_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_WIDTH = 6;
  localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/vout_serializer.sv
// Parallel-to-serial converter for the upstream vout bus.
// Accepts a word over a valid/ready handshake and shifts it out one bit per
// cycle, optionally followed by an even-parity beat. A one-word pending
// buffer lets frames run back-to-back with no idle cycle between them.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   din_valid : upstream word valid
//   din_ready : a word can be accepted this cycle
//   din       : parallel word
//   sout      : serial data bit (registered)
//   sframe    : high on every data/parity beat (registered)
//   slast     : high on the final beat of a frame (registered)
module vout_serializer
  import vout_ser_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int PARITY    = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sframe,
  output logic             slast
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shreg_reg, shreg_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               par_reg, par_next;
  logic [WIDTH-1:0]   pend_reg, pend_next;
  logic               pend_valid_reg, pend_valid_next;
  logic               sout_reg, sout_next;
  logic               sframe_reg, sframe_next;
  logic               slast_reg, slast_next;

  logic               last_beat;
  logic               load_now;
  logic               xfer;
  logic               load;
  logic [WIDTH-1:0]   load_word;

  assign din_ready = !pend_valid_reg && !rst;
  assign xfer      = din_valid && din_ready;
  assign sout      = sout_reg;
  assign sframe    = sframe_reg;
  assign slast     = slast_reg;

  always_comb begin
    last_beat       = ((state_reg == DATA) && (cnt_reg == CNT_LAST) && (PARITY == 0))
                      || (state_reg == PAR);
    load_now        = (state_reg == IDLE) || (last_beat && !pend_valid_reg);

    state_next      = state_reg;
    shreg_next      = shreg_reg;
    cnt_next        = cnt_reg;
    par_next        = par_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    load            = 1'b0;
    load_word       = din;

    // Advance within a frame; the counter saturates at the last data bit.
    if (state_reg == DATA) begin
      if (cnt_reg != CNT_LAST) begin
        cnt_next   = cnt_reg + CW'(1);
        shreg_next = (MSB_FIRST != 0) ? (shreg_reg << 1) : (shreg_reg >> 1);
      end else if (PARITY != 0) begin
        state_next = PAR;
      end
    end

    // Frame end: chain the pending word, else drop to IDLE (a same-cycle
    // transfer below may still override that with a direct load).
    if (last_beat) begin
      if (pend_valid_reg) begin
        load            = 1'b1;
        load_word       = pend_reg;
        pend_valid_next = 1'b0;
      end else begin
        state_next = IDLE;
      end
    end

    // din_ready implies an empty buffer, so this never collides with the
    // pending-word load above.
    if (xfer) begin
      if (load_now) begin
        load      = 1'b1;
        load_word = din;
      end else begin
        pend_next       = din;
        pend_valid_next = 1'b1;
      end
    end

    // Parity is latched from the whole word at load, not from shifted bits.
    if (load) begin
      state_next = DATA;
      cnt_next   = '0;
      shreg_next = load_word;
      par_next   = ^load_word;
    end

    // Outputs are computed from the next state so they register alongside it.
    sout_next   = 1'b0;
    if (state_next == DATA) begin
      sout_next = (MSB_FIRST != 0) ? shreg_next[WIDTH-1] : shreg_next[0];
    end else if (state_next == PAR) begin
      sout_next = par_next;
    end
    sframe_next = (state_next != IDLE);
    slast_next  = ((state_next == DATA) && (cnt_next == CNT_LAST) && (PARITY == 0))
                  || (state_next == PAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      cnt_reg        <= '0;
      par_reg        <= 1'b0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      sout_reg       <= 1'b0;
      sframe_reg     <= 1'b0;
      slast_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      cnt_reg        <= cnt_next;
      par_reg        <= par_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      sout_reg       <= sout_next;
      sframe_reg     <= sframe_next;
      slast_reg      <= slast_next;
    end
  end

endmodule

// File: tb/tb_vout_serializer.sv
// Bench for vout_serializer: three instances (no parity MSB-first, parity
// MSB-first, no parity LSB-first). Expected beats are queued per instance on
// each accepted word and compared as sframe beats appear; directed sequences
// check timing, handshake and reset behaviour.
module tb_vout_serializer;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   dv;
  logic [2:0]   dr, so, sf, sl;
  logic [W-1:0] dd0, dd1, dd2;

  int errors = 0;
  int checks = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  always #5 clk = ~clk;

  vout_serializer #(.WIDTH(W), .PARITY(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .din_valid(dv[0]), .din_ready(dr[0]), .din(dd0),
    .sout(so[0]), .sframe(sf[0]), .slast(sl[0]));

  vout_serializer #(.WIDTH(W), .PARITY(1), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .din_valid(dv[1]), .din_ready(dr[1]), .din(dd1),
    .sout(so[1]), .sframe(sf[1]), .slast(sl[1]));

  vout_serializer #(.WIDTH(W), .PARITY(0), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .din_valid(dv[2]), .din_ready(dr[2]), .din(dd2),
    .sout(so[2]), .sframe(sf[2]), .slast(sl[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected beats {sout, slast} for one word on instance i.
  task automatic push_frame(input int i, input logic [W-1:0] w);
    int par;
    int msb;
    int n;
    par = (i == 1) ? 1 : 0;
    msb = (i == 2) ? 0 : 1;
    n   = W + par;
    for (int k = 0; k < n; k++) begin
      logic       b;
      logic [1:0] e;
      if (k < W) b = (msb != 0) ? w[W-1-k] : w[k];
      else       b = ^w;
      e = {b, (k == n - 1) ? 1'b1 : 1'b0};
      case (i)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic mon_beat(input int i, input logic s, input logic f, input logic l);
    logic [1:0] e;
    int         sz;
    if (!f) begin
      check($sformatf("idle_sout%0d", i), s, 0);
      check($sformatf("idle_slast%0d", i), l, 0);
      return;
    end
    case (i)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      check($sformatf("unexpected_beat%0d", i), f, 0);
      return;
    end
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    checks++;
    if (s !== e[1] || l !== e[0]) begin
      errors++;
      $display("FAIL beat%0d: got sout=%0b slast=%0b expected sout=%0b slast=%0b",
               i, s, l, e[1], e[0]);
    end
  endtask

  // Accepted words: sampled at the edge, before the DUT's state updates.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (dv[0] && dr[0]) push_frame(0, dd0);
      if (dv[1] && dr[1]) push_frame(1, dd1);
      if (dv[2] && dr[2]) push_frame(2, dd2);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      mon_beat(0, so[0], sf[0], sl[0]);
      mon_beat(1, so[1], sf[1], sl[1]);
      mon_beat(2, so[2], sf[2], sl[2]);
    end
  end

  task automatic set_din(input int i, input logic [W-1:0] w);
    case (i)
      0:       dd0 = w;
      1:       dd1 = w;
      default: dd2 = w;
    endcase
  endtask

  // Present a word and hold it until accepted; returns 1 unit after the
  // transfer edge, i.e. inside the first beat.
  task automatic send(input int i, input logic [W-1:0] w);
    int n;
    n = 0;
    set_din(i, w);
    dv[i] = 1'b1;
    while (!dr[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check($sformatf("send_timeout%0d", i), dr[i], 1);
    @(posedge clk); #1;
    dv[i] = 1'b0;
  endtask

  initial begin
    dv  = '0;
    dd0 = '0;
    dd1 = '0;
    dd2 = '0;
    rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", dr, 3'b000);
    check("rst_sframe", sf, 3'b000);
    check("rst_sout", so, 3'b000);
    check("rst_slast", sl, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", dr, 3'b111);

    // Single frame, no parity: 6 beats, slast on the 6th only
    send(0, 6'b101101);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("single_sframe_b%0d", k), sf[0], 1);
      check($sformatf("single_slast_b%0d", k), sl[0], (k == 5) ? 1 : 0);
    end
    @(negedge clk);
    check("single_idle_sframe", sf[0], 0);
    check("single_idle_sout", so[0], 0);

    // Parity frames: 7 beats, slast on the parity beat
    send(1, 6'b101101);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("par_sframe_b%0d", k), sf[1], 1);
      check($sformatf("par_slast_b%0d", k), sl[1], (k == 6) ? 1 : 0);
    end
    @(negedge clk);
    check("par_idle_sframe", sf[1], 0);
    send(1, 6'b100000);
    repeat (8) @(negedge clk);

    // Back-to-back: 3F then 15 with valid held high
    @(posedge clk); #1;
    dd0   = 6'h3F;
    dv[0] = 1'b1;
    @(posedge clk); #1;
    dd0 = 6'h15;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    for (int b = 1; b < 12; b++) begin
      @(negedge clk);
      check($sformatf("b2b_sframe_b%0d", b), sf[0], 1);
      check($sformatf("b2b_ready_b%0d", b), dr[0], (b >= 6) ? 1 : 0);
      check($sformatf("b2b_slast_b%0d", b), sl[0], (b == 5 || b == 11) ? 1 : 0);
    end
    @(negedge clk);
    check("b2b_idle_sframe", sf[0], 0);

    // Transfer on the last beat with an empty buffer
    @(posedge clk); #1;
    dd0   = 6'h3F;
    dv[0] = 1'b1;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("lb_last", sl[0], 1);
    dd0   = 6'h2A;
    dv[0] = 1'b1;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    @(negedge clk);
    check("lb_next_sframe", sf[0], 1);
    check("lb_next_slast", sl[0], 0);
    check("lb_no_pend", dr[0], 1);
    repeat (6) @(negedge clk);
    check("lb_idle_sframe", sf[0], 0);

    // Reset mid-frame with a word pending
    @(posedge clk); #1;
    dd0   = 6'h3F;
    dv[0] = 1'b1;
    @(posedge clk); #1;
    dd0 = 6'h15;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    @(negedge clk);
    check("rstmid_pend_held", dr[0], 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_sframe", sf[0], 0);
    check("rstmid_sout", so[0], 0);
    check("rstmid_ready", dr[0], 1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_quiet%0d", k), sf[0], 0);
    end

    // LSB-first
    send(2, 6'b000001);
    @(negedge clk);
    check("lsb_slast_b1", sl[2], 0);
    repeat (6) @(negedge clk);

    // Random traffic on all instances
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      dv[0] = 1'($urandom_range(0, 1));
      dv[1] = 1'($urandom_range(0, 1));
      dv[2] = 1'($urandom_range(0, 1));
      dd0   = W'($urandom);
      dd1   = W'($urandom);
      dd2   = W'($urandom);
    end
    @(posedge clk); #1;
    dv = '0;
    repeat (40) @(negedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vout_serializer.md
Name: vout_serializer

Overview:
- Downstream consumer of the parallel output bus `vout`, whose width is `v2kparam+1` (6 bits at the default `v2kparam` = 5).
- Accepts parallel words over a valid/ready handshake and shifts each one out serially, MSB first.
- Can append an even-parity bit after the data bits.
- A one-entry pending buffer lets frames run back-to-back with no idle cycles between them.

Parameters:
- WIDTH, 6, parallel word width (= v2kparam+1 of the upstream stage).
- PARITY, 0, 0 = no parity beat; 1 = append an even-parity beat after the data bits.
- MSB_FIRST, 1, 1 = shift din[WIDTH-1] first; 0 = shift din[0] first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din_valid  input  1  upstream word valid.
- din_ready  output  1  block can accept a word this cycle.
- din  input  WIDTH  parallel word (the upstream vout).
- sout  output  1  serial data bit.
- sframe  output  1  high on every beat that carries a data or parity bit.
- slast  output  1  high on the final beat of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, shift register=0, bit counter=0, pend_valid=0.
  - sout=0, sframe=0, slast=0, din_ready=0 during the reset cycle.
  - din_ready=1 from the first cycle after reset deasserts.
  - Any frame in flight and any pending word are discarded without further output.
- Handshake:
  - A transfer occurs at a clock edge where din_valid && din_ready.
  - din_ready = !pend_valid && !rst.
  - din is sampled only on a transfer. din_valid without din_ready has no effect.
- States: IDLE, DATA, PAR (PAR exists only when PARITY=1).
- Definitions:
  - last_beat = (DATA && cnt==WIDTH-1 && PARITY==0) || PAR.
  - load_now = IDLE || (last_beat && !pend_valid).
- Transfer routing:
  - If load_now, the word loads the shifter and the next state is DATA with cnt=0.
  - Otherwise the word goes into the pending buffer and pend_valid is set.
- End of frame:
  - On last_beat with pend_valid=1, the pending word loads the shifter, pend_valid clears, and the next state is DATA with cnt=0. This gives zero gap between frames.
  - On last_beat with no load, the next state is IDLE.
- Latency: first bit appears on sout in the cycle after the transfer edge (1-cycle latency).
- Outputs by state:
  - DATA: sout = current shifter bit; sframe=1; cnt increments each cycle.
  - DATA→PAR transition happens when cnt==WIDTH-1 and PARITY=1.
  - PAR: sout = XOR of all WIDTH bits of the frame word (even parity, so the total count of ones is even); sframe=1.
  - IDLE: sout=0, sframe=0, slast=0.
  - slast=1 exactly on last_beat.
- Registered outputs: sout, sframe and slast are registered, so no combinational path from din to sout.
- Parity: computed and latched at load time from the loaded word, not from shifted bits.
- Counter: width $clog2(WIDTH) with a minimum of 1. It never wraps past WIDTH-1 and resets to 0 on every load.
- Simultaneous events: a transfer on the last_beat cycle with an empty buffer goes straight to the shifter. pend_valid never holds more than one word.

Decomposition:
- Shared package vout_ser_pkg holds:
  - state enum typedef (IDLE/DATA/PAR);
  - localparam CNT_W.
- No sub-module. The pending buffer is a single register plus valid bit, kept inline.

Test Plan:
- Reset then single word, WIDTH=6, PARITY=0, din=6'b101101 → sout 1,0,1,1,0,1 on cycles t+1..t+6; sframe high for 6 cycles; slast only at t+6; then IDLE with sout=0.
- PARITY=1, din=6'b101101 → six data beats then a parity beat with sout=0 (four ones); slast on the 7th beat only. Repeat with 6'b100000 → parity beat sout=1.
- Back-to-back with din_valid held high, words 6'h3F then 6'h15 → second word is held in the buffer while din_ready=0; 12 consecutive sframe beats with no gap; din_ready returns to 1 on the cycle after the second frame loads.
- Transfer on the last_beat cycle with an empty buffer (word 6'h2A) → next cycle is data beat 0 of the new frame and pend_valid stays 0.
- rst asserted on beat 3 of a frame with a word pending → next cycle sframe=0, sout=0, pend_valid=0; the pending word is never emitted; din_ready=1 after rst drops.
- MSB_FIRST=0, din=6'b000001 → sout 1,0,0,0,0,0.
